// File: rtl/decoder_pkg.sv
// Shared types and helpers for the modular decoder slice.
package decoder_pkg;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned MAX_R    = 32;
    localparam int unsigned MOD_BITS = MAX_CH * MAX_R;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFinish} state_e;

    // Pull channel idx's modulus out of a packed moduli vector (zero-extended to MOD_BITS).
    function automatic int unsigned mod_of(input logic [MOD_BITS-1:0] moduli,
                                           input int unsigned         r_width,
                                           input int unsigned         idx);
        int unsigned res;
        logic [7:0]  pos;
        res = 0;
        for (int unsigned b = 0; b < MAX_R; b++) begin
            if (b < r_width) begin
                pos = 8'(idx * r_width + b);
                res[b[4:0]] = moduli[pos];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/modular_decoder_if.sv
// Dividend in, remainders/quotients and status out.
interface modular_decoder_if #(
    parameter int unsigned W_WIDTH = 13,
    parameter int unsigned R_WIDTH = 7,
    parameter int unsigned N_CH    = 2
);
    logic [W_WIDTH-1:0]        W;
    logic [N_CH*R_WIDTH-1:0]   rem_o;
    logic [N_CH*W_WIDTH-1:0]   quo_o;
    logic                      done;
    logic                      result_stb;
    logic                      busy;

    modport master (output W, input rem_o, quo_o, done, result_stb, busy);
    modport slave  (input W, output rem_o, quo_o, done, result_stb, busy);
endinterface

// File: rtl/mod_divider_core.sv
// One restoring-division lane by a constant modulus M, one quotient bit per step.
module mod_divider_core #(
    parameter int unsigned W_WIDTH = 13,
    parameter int unsigned R_WIDTH = 7,
    parameter int unsigned M       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [W_WIDTH-1:0] dividend,
    output logic [R_WIDTH-1:0] rem,
    output logic [W_WIDTH-1:0] quo
);
    localparam logic [R_WIDTH:0] MOD = (R_WIDTH+1)'(M);

    logic [R_WIDTH:0]   pr_q;   // partial remainder, MSB only matters during the trial
    logic [W_WIDTH-1:0] dq_q;   // dividend bits shift out the top, quotient bits in the bottom
    logic [R_WIDTH:0]   trial;
    logic               fits;
    logic               unused_pr_msb;

    // Trial subtraction of the next shifted-in dividend bit.
    always_comb begin
        trial = {pr_q[R_WIDTH-1:0], dq_q[W_WIDTH-1]};
        fits  = (trial >= MOD);
    end

    // Load a fresh dividend or perform one restoring step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr_q <= '0;
            dq_q <= '0;
        end else if (load) begin
            pr_q <= '0;
            dq_q <= dividend;
        end else if (step) begin
            pr_q <= fits ? (trial - MOD) : trial;
            dq_q <= {dq_q[W_WIDTH-2:0], fits};
        end
    end

    assign rem           = pr_q[R_WIDTH-1:0];
    assign quo           = dq_q;
    assign unused_pr_msb = pr_q[R_WIDTH];

endmodule

// File: rtl/modular_decoder.sv
// Multi-channel W mod M[i] / W div M[i] decoder that recomputes whenever W changes.
module modular_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned               W_WIDTH = 13,
    parameter int unsigned               R_WIDTH = 7,
    parameter int unsigned               N_CH    = 2,
    parameter logic [N_CH*R_WIDTH-1:0]   MODULI  = {7'd81, 7'd80}
) (
    input  logic             clk,
    input  logic             reset,
    modular_decoder_if.slave bus
);
    localparam int unsigned         CNT_W      = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1;
    localparam logic [MOD_BITS-1:0] MODULI_EXT = MOD_BITS'(MODULI);

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
        $error("modular_decoder: N_CH=%0d outside 1..%0d", N_CH, MAX_CH);
    end

    state_e                  state_q;
    logic [W_WIDTH-1:0]      w_last;
    logic                    pending;
    logic [CNT_W-1:0]        cnt_q;
    logic                    done_q;
    logic                    stb_q;
    logic                    busy_q;
    logic [N_CH*R_WIDTH-1:0] rem_q;
    logic [N_CH*R_WIDTH-1:0] rem_all;
    logic [N_CH*W_WIDTH-1:0] quo_q;
    logic [N_CH*W_WIDTH-1:0] quo_all;
    logic                    changed;
    logic                    core_load;
    logic                    core_step;

    assign changed   = (bus.W != w_last);
    assign core_load = (state_q == StLoad);
    assign core_step = (state_q == StRun);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int unsigned MI = mod_of(MODULI_EXT, R_WIDTH, i);
        if (MI == 0 || (MI >> R_WIDTH) != 0) begin : g_bad_mod
            $error("modular_decoder: channel %0d modulus %0d out of range", i, MI);
        end
        mod_divider_core #(
            .W_WIDTH (W_WIDTH),
            .R_WIDTH (R_WIDTH),
            .M       (MI)
        ) u_core (
            .clk      (clk),
            .reset    (reset),
            .load     (core_load),
            .step     (core_step),
            .dividend (w_last),
            .rem      (rem_all[i*R_WIDTH +: R_WIDTH]),
            .quo      (quo_all[i*W_WIDTH +: W_WIDTH])
        );
    end

    // Control FSM: change detection, step counting and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            w_last  <= '0;
            pending <= 1'b1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            stb_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pending || changed) begin
                        w_last  <= bus.W;
                        done_q  <= 1'b0;
                        pending <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (changed) begin
                        w_last <= bus.W;  // reload with the new value next cycle
                    end else begin
                        cnt_q   <= CNT_W'(W_WIDTH - 1);
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (changed) begin
                        w_last  <= bus.W;
                        state_q <= StLoad;
                    end else if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= StFinish;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StFinish: begin
                    if (changed) begin
                        // Abandon: outputs keep the last completed result, no strobe.
                        w_last  <= bus.W;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end else begin
                        rem_q   <= rem_all;
                        quo_q   <= quo_all;
                        done_q  <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rem_o      = rem_q;
    assign bus.quo_o      = quo_q;
    assign bus.done       = done_q;
    assign bus.result_stb = stb_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_modular_decoder.sv
// Bench for modular_decoder: directed scenarios plus random W traffic against a countdown model.
module tb_modular_decoder;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    modular_decoder_if #(.W_WIDTH(13), .R_WIDTH(7), .N_CH(2)) bus_a ();
    modular_decoder_if #(.W_WIDTH(16), .R_WIDTH(7), .N_CH(4)) bus_b ();

    modular_decoder dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    modular_decoder #(
        .W_WIDTH (16),
        .R_WIDTH (7),
        .N_CH    (4),
        .MODULI  ({7'd127, 7'd7, 7'd5, 7'd3})
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference model: a result appears W_WIDTH+2 edges after the last observed change.
    int unsigned      mods[2] = '{80, 81};
    logic [12:0]      m_last = '0;
    bit               m_pending = 1'b1;
    int               m_remain = 0;
    bit               m_done = 1'b0;
    bit               m_stb = 1'b0;
    logic [13:0]      m_rem = '0;
    logic [25:0]      m_quo = '0;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            m_last <= '0; m_pending <= 1'b1; m_remain <= 0;
            m_done <= 1'b0; m_stb <= 1'b0; m_rem <= '0; m_quo <= '0;
        end else begin
            m_stb <= 1'b0;
            if (m_pending || bus_a.W != m_last) begin
                m_last    <= bus_a.W;
                m_pending <= 1'b0;
                m_done    <= 1'b0;
                m_remain  <= 15;
            end else if (m_remain > 0) begin
                m_remain <= m_remain - 1;
                if (m_remain == 1) begin
                    m_done <= 1'b1;
                    m_stb  <= 1'b1;
                    for (int c = 0; c < 2; c++) begin
                        m_rem[c*7 +: 7]   <= 7'(int'(m_last) % mods[c]);
                        m_quo[c*13 +: 13] <= 13'(int'(m_last) / mods[c]);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of DUT A against the model, mid-cycle.
    always @(negedge clk) begin
        check("done", 64'(bus_a.done), 64'(m_done));
        check("stb", 64'(bus_a.result_stb), 64'(m_stb));
        check("busy", 64'(bus_a.busy), 64'(m_remain >= 2));
        check("rem", 64'(bus_a.rem_o), 64'(m_rem));
        check("quo", 64'(bus_a.quo_o), 64'(m_quo));
    end

    task automatic wait_done(input bit use_b, output int lat, output int stbs);
        lat  = -1;
        stbs = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if ((use_b ? bus_b.result_stb : bus_a.result_stb) === 1'b1) stbs++;
            if ((use_b ? bus_b.done : bus_a.done) === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    int lat;
    int stbs;
    int cnt_done;
    int cnt_stb;
    int cnt_busy;
    int r;

    initial begin
        bus_a.W = '0;
        bus_b.W = 16'd65535;
        #1 rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        check("rst_done", 64'(bus_a.done), 64'd0);
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_rem", 64'(bus_a.rem_o), 64'd0);

        // First computation straight out of reset.
        bus_a.W = 13'd1000;
        rst_a   = 1'b0;
        wait_done(1'b0, lat, stbs);
        check("lat_1000", 64'(lat), 64'd15);
        check("rem_1000", 64'(bus_a.rem_o), 64'({7'd28, 7'd40}));
        check("quo_1000", 64'(bus_a.quo_o), 64'({13'd12, 13'd12}));
        @(negedge clk);
        check("stb_1cyc", 64'(bus_a.result_stb), 64'd0);

        bus_a.W = 13'd8191;
        wait_done(1'b0, lat, stbs);
        check("lat_8191", 64'(lat), 64'd15);
        check("rem_8191", 64'(bus_a.rem_o), 64'({7'd10, 7'd31}));
        check("quo_8191", 64'(bus_a.quo_o), 64'({13'd101, 13'd102}));

        @(negedge clk);
        bus_a.W = 13'd0;
        wait_done(1'b0, lat, stbs);
        check("lat_0", 64'(lat), 64'd15);
        check("rem_0", 64'(bus_a.rem_o), 64'd0);
        check("quo_0", 64'(bus_a.quo_o), 64'd0);

        // Change mid-computation: 1000 is abandoned, only 8191 completes.
        @(negedge clk);
        bus_a.W  = 13'd1000;
        cnt_done = 0;
        cnt_stb  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_a.done) cnt_done++;
            if (bus_a.result_stb) cnt_stb++;
        end
        bus_a.W = 13'd8191;
        wait_done(1'b0, lat, stbs);
        check("abort_done", 64'(cnt_done), 64'd0);
        check("abort_lat", 64'(lat), 64'd15);
        check("abort_stbs", 64'(cnt_stb + stbs), 64'd1);
        check("abort_rem", 64'(bus_a.rem_o), 64'({7'd10, 7'd31}));

        // Quiet period: nothing should move.
        cnt_stb  = 0;
        cnt_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_a.result_stb) cnt_stb++;
            if (bus_a.busy) cnt_busy++;
        end
        check("hold_stb", 64'(cnt_stb), 64'd0);
        check("hold_busy", 64'(cnt_busy), 64'd0);
        check("hold_rem", 64'(bus_a.rem_o), 64'({7'd10, 7'd31}));
        check("hold_quo", 64'(bus_a.quo_o), 64'({13'd101, 13'd102}));

        // Reset in the middle of RUN.
        bus_a.W = 13'd1000;
        repeat (6) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("mid_rst_rem", 64'(bus_a.rem_o), 64'd0);
        check("mid_rst_quo", 64'(bus_a.quo_o), 64'd0);
        check("mid_rst_busy", 64'(bus_a.busy), 64'd0);
        @(negedge clk);
        #2 rst_a = 1'b0;
        wait_done(1'b0, lat, stbs);
        check("post_rst_lat", 64'(lat), 64'd15);
        check("post_rst_rem", 64'(bus_a.rem_o), 64'({7'd28, 7'd40}));

        // Random traffic, including single-bit glitches and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                bus_a.W = 13'($urandom_range(0, 8191));
            end else if (r < 6) begin
                bus_a.W = bus_a.W ^ (13'd1 << $urandom_range(0, 12));
            end else if (r == 6 && $urandom_range(0, 9) == 0) begin
                #2 rst_a = 1'b1;
                #2 rst_a = 1'b0;
            end
        end

        // Four-channel, 16-bit configuration.
        @(negedge clk);
        rst_b = 1'b0;
        wait_done(1'b1, lat, stbs);
        check("b_lat", 64'(lat), 64'd18);
        check("b_stbs", 64'(stbs), 64'd1);
        check("b_rem", 64'(bus_b.rem_o), 64'({7'd3, 7'd1, 7'd0, 7'd0}));
        check("b_quo", 64'(bus_b.quo_o), {16'd516, 16'd9362, 16'd13107, 16'd21845});
        @(negedge clk);
        check("b_stb_1cyc", 64'(bus_b.result_stb), 64'd0);
        check("b_busy", 64'(bus_b.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
